mag_sq_feeder: RTL
==================

# mag_sq_feeder

Operand front-end for the `sqrt_newton` core. It accepts a signed 2-D vector (a, b) on a valid/ready handshake and computes the squared magnitude a² + b² with one serial shift-add multiplier. It presents the result on `x` with a one-cycle `start` pulse, then holds it until the core reports `done`. Together with `sqrt_newton` it forms a vector-magnitude path.

## Interface
- `W`, default 16: component width; the result is 2W bits.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair.
- `a`  in  W  signed component.
- `b`  in  W  signed component.
- `x`  out  2W  squared magnitude (signed); drives the core's `x`.
- `start`  out  1  one-cycle pulse to the core's `start`.
- `done`  in  1  from the core's `done`.
- `busy`  out  1  an operation is in flight.
- `ovf`  out  1  result saturated; valid alongside `x`.

## Operation
- FSM states: IDLE, SQ_A, SQ_B, ISSUE, WAIT.
- **IDLE.** `in_ready`=1. When `in_valid`&&`in_ready`:
  - latch |a| and |b| as W-bit unsigned values; |−2^(W−1)| = 2^(W−1) is representable.
  - clear the accumulator.
  - go to SQ_A.
- **SQ_A.** W cycles, one multiplier bit per cycle, computing |a|·|a| into a 2W-bit unsigned accumulator. Then go to SQ_B.
- **SQ_B.** W cycles, computing |b|·|b|. The sum uses a (2W+1)-bit adder. Then go to ISSUE.
- **ISSUE.** One cycle:
  - register `x` = sum if sum ≤ 2^(2W−1)−1; otherwise `x` = 2^(2W−1)−1 and `ovf`=1.
  - overflow occurs only when a = b = −2^(W−1).
  - `start`=1 for exactly this cycle.
  - go to WAIT.
- **WAIT.** `x` and `ovf` are held stable. On `done`=1, go to IDLE. `x` and `ovf` keep their values until the next ISSUE.
- `done` is ignored in every state except WAIT.
- `busy`=1 in every state except IDLE. `in_ready` = (state == IDLE), combinational.
- `in_valid` while busy: the pair is not accepted. The upstream holds it and it is taken in the first IDLE cycle.
- **Reset**, including mid-operation: state goes to IDLE; `x`=0, `ovf`=0, `start`=0, `busy`=0, accumulator cleared. `in_ready`=1 from the first cycle after reset deasserts. No `start` is issued for the aborted operation.

## Timing
- Accept edge = cycle 0.
- SQ_A occupies cycles 1..W. SQ_B occupies cycles W+1..2W.
- ISSUE at cycle 2W+1: `start` high and `x`/`ovf` valid in that same cycle. For W=16 this is cycle 33.
- If `done` is sampled high at cycle D in WAIT, the block is in IDLE with `in_ready`=1 at cycle D+1.
- Back-to-back pairs: minimum issue spacing is 2W+3 cycles (done arriving the cycle after ISSUE).
- All outputs except `in_ready` are registered.
- Zero-latency bypass is not supported. Zero operands still take the full 2W+1 cycles.

## Structure
- Package `sqrt_pkg` holds:
  - the `state_t` enum (IDLE, SQ_A, SQ_B, ISSUE, WAIT);
  - `localparam` default W = 16;
  - a function returning the saturation constant 2^(2W−1)−1.
- Sub-module `sq_serial`: unsigned W×W shift-add multiplier.
  - Ports: `clk`, `rst`, `load`, `op`, `prod`, `fin`.
  - It is instantiated once and reused for both components.
  - The parent FSM sequences it and accumulates the two products.

## Test plan
- (a=3, b=4) accepted at cycle 0 → `start` pulses at cycle 33 only, `x`=25, `ovf`=0. `x` stays 25 and `in_ready`=0 until `done`; `in_ready`=1 the cycle after `done`.
- (0, 0) → `x`=0, `ovf`=0, `start` at cycle 33. (−5, 12) → `x`=169.
- (−32768, −32768) → `x`=2147483647, `ovf`=1. (−32768, 0) → `x`=1073741824, `ovf`=0.
- `in_valid` held high with new data during WAIT → no acceptance until after `done`, then exactly one acceptance. `done` pulsed during SQ_A → ignored, `start` still occurs at cycle 33.
- `rst` asserted during SQ_B → next cycle `x`=0, `busy`=0, `start` never pulses. A following pair (6, 8) → `x`=100.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the vector-magnitude front-end
// and the sqrt_newton core.
package sqrt_pkg;

    localparam int W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        SQ_A,
        SQ_B,
        ISSUE,
        WAIT
    } state_t;

    // Largest positive value of a signed 2w-bit result.
    function automatic logic [127:0] sat_max(input int w);
        return (128'd1 << (2 * w - 1)) - 128'd1;
    endfunction

endpackage

// File: rtl/sq_serial.sv
// Unsigned W x W shift-add multiplier, one multiplier bit per cycle.
// prod/fin are the running values including the current step.
module sq_serial
    import sqrt_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [W-1:0]   op,
    output logic [2*W-1:0] prod,
    output logic           fin
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;

    assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign fin  = run_q && (cnt_q == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (load) begin
            mcand_q  <= {{W{1'b0}}, op};
            mplier_q <= op;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= prod;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            run_q    <= !fin;
        end
    end

endmodule

// File: rtl/mag_sq_feeder.sv
// Computes a^2 + b^2 serially and hands it to sqrt_newton with a
// start pulse, holding the result until the core reports done.
module mag_sq_feeder
    import sqrt_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] x,
    output logic           start,
    input  logic           done,
    output logic           busy,
    output logic           ovf
);

    localparam logic [2*W-1:0] SAT = (2 * W)'(sat_max(W));

    function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
        return v[W-1] ? (~v + W'(1)) : v;
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   b_abs_q, b_abs_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] x_q, x_d;
    logic           ovf_q, ovf_d;
    logic           start_q, start_d;
    logic           busy_q, busy_d;

    logic           mul_load;
    logic [W-1:0]   mul_op;
    logic [2*W-1:0] mul_prod;
    logic           mul_fin;
    logic [2*W:0]   sum;

    sq_serial #(.W(W)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (mul_load),
        .op   (mul_op),
        .prod (mul_prod),
        .fin  (mul_fin)
    );

    assign sum      = {1'b0, acc_q} + {1'b0, mul_prod};
    assign in_ready = (state_q == IDLE);
    assign x        = x_q;
    assign ovf      = ovf_q;
    assign start    = start_q;
    assign busy     = busy_q;

    always_comb begin
        state_d  = state_q;
        b_abs_d  = b_abs_q;
        acc_d    = acc_q;
        x_d      = x_q;
        ovf_d    = ovf_q;
        start_d  = 1'b0;
        mul_load = 1'b0;
        mul_op   = b_abs_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                b_abs_d  = abs_w(b);
                acc_d    = '0;
                mul_load = 1'b1;
                mul_op   = abs_w(a);
                state_d  = SQ_A;
            end
            SQ_A: if (mul_fin) begin
                // Bank a^2 and reuse the multiplier for b^2.
                acc_d    = mul_prod;
                mul_load = 1'b1;
                state_d  = SQ_B;
            end
            SQ_B: if (mul_fin) begin
                if (sum > {1'b0, SAT}) begin
                    x_d   = SAT;
                    ovf_d = 1'b1;
                end else begin
                    x_d   = sum[2*W-1:0];
                    ovf_d = 1'b0;
                end
                start_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            b_abs_q <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_abs_q <= b_abs_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            ovf_q   <= ovf_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

endmodule
